kb_scr_host: RTL and testbench

- Host-side peer of the keyboard/screen CSR driver.
- Keyboard path: buffers keystroke bytes and strobes them onto the driver's write port (`write_en` / `data_bus_i`), then waits for `write_ok`.
- Screen path: answers the driver's read request (`read_en` / `data_bus_o`) with a one-cycle `read_ok`, then hands the captured byte to a downstream sink (UART TX / terminal) over valid/ready.

---
 rtl/kb_scr_pkg.sv | 31 +++
 rtl/kb_scr_host_byte_fifo.sv | 52 +++++
 rtl/kb_scr_host.sv | 148 ++++++++++++++
 tb/tb_kb_scr_host.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_scr_pkg.sv
// Shared constants for the keyboard/screen host link: control bit indices,
// TX/RX state encodings and the CSR bit layout used by the peer driver.
package kb_scr_pkg;

  // link_ctrl_o bit positions
  localparam int WREN = 1;
  localparam int RDOK = 0;

  // link_ctrl_i bit positions
  localparam int RDEN = 1;
  localparam int WROK = 0;

  // Keyboard-to-driver FSM states
  localparam logic [1:0] TX_IDLE     = 2'd0;
  localparam logic [1:0] TX_STROBE   = 2'd1;
  localparam logic [1:0] TX_WAIT_ACK = 2'd2;
  localparam logic [1:0] TX_GAP      = 2'd3;

  // Driver-to-screen FSM states
  localparam logic [1:0] RX_IDLE    = 2'd0;
  localparam logic [1:0] RX_ACK     = 2'd1;
  localparam logic [1:0] RX_RELEASE = 2'd2;

  // CSR bit positions shared with the driver
  localparam int CSR_ENA = 4;
  localparam int CSR_OF  = 3;
  localparam int CSR_DBA = 2;
  localparam int CSR_IO  = 1;
  localparam int CSR_IE  = 0;

endpackage

// File: rtl/kb_scr_host_byte_fifo.sv
// Small 8-bit FIFO with occupancy count. DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is honoured only when a pop
// happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage array; contents need no reset because the count gates reads
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kb_scr_host.sv
// Host-side peer of the keyboard/screen CSR driver. Keystrokes are queued and
// strobed to the driver one at a time; screen bytes requested by the driver
// are captured, acknowledged, and handed to a downstream sink.
module kb_scr_host #(
  parameter int KB_FIFO_DEPTH = 4,
  parameter int ACK_TIMEOUT   = 255,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        key_data_i,
  input  logic                              key_valid_i,
  output logic                              key_ready_o,
  output logic [7:0]                        link_data_o,
  output logic [1:0]                        link_ctrl_o,
  input  logic [7:0]                        link_data_i,
  input  logic [1:0]                        link_ctrl_i,
  output logic [7:0]                        scr_data_o,
  output logic                              scr_valid_o,
  input  logic                              scr_ready_i,
  output logic [$clog2(KB_FIFO_DEPTH):0]    kb_count_o,
  output logic                              kb_timeout_o
);

  import kb_scr_pkg::*;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [1:0]    tx_state;
  logic [TW-1:0] ack_cnt;
  logic [GW-1:0] gap_cnt;
  logic          wren_q;
  logic          timeout_q;
  logic [7:0]    link_data_q;

  logic [1:0]    rx_state;
  logic          rdok_q;
  logic          scr_valid_q;
  logic [7:0]    scr_data_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  assign key_ready_o = !fifo_full;
  assign fifo_push   = key_valid_i && key_ready_o;
  assign fifo_pop    = (tx_state == TX_IDLE) && !fifo_empty;

  byte_fifo #(
    .DEPTH(KB_FIFO_DEPTH)
  ) u_kb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (key_data_i),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (kb_count_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Keyboard TX: pop, strobe write_en for one cycle, wait for write_ok or give up, then pause
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      ack_cnt     <= '0;
      gap_cnt     <= '0;
      wren_q      <= 1'b0;
      timeout_q   <= 1'b0;
      link_data_q <= '0;
    end else begin
      wren_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            link_data_q <= fifo_head;
            wren_q      <= 1'b1;
            tx_state    <= TX_STROBE;
          end
        end
        TX_STROBE: begin
          ack_cnt  <= '0;
          tx_state <= TX_WAIT_ACK;
        end
        TX_WAIT_ACK: begin
          if (link_ctrl_i[WROK]) begin
            gap_cnt  <= GW'(GAP_CYCLES - 1);
            tx_state <= TX_GAP;
          end else if (ack_cnt == TW'(ACK_TIMEOUT)) begin
            gap_cnt   <= GW'(GAP_CYCLES - 1);
            timeout_q <= 1'b1;
            tx_state  <= TX_GAP;
          end else begin
            ack_cnt <= ack_cnt + TW'(1);
          end
        end
        TX_GAP: begin
          if (gap_cnt == '0) tx_state <= TX_IDLE;
          else               gap_cnt  <= gap_cnt - GW'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Screen RX: capture when the holding register is free, ack once, then wait for read_en to drop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      rdok_q      <= 1'b0;
      scr_valid_q <= 1'b0;
      scr_data_q  <= '0;
    end else begin
      rdok_q <= 1'b0;
      if (scr_valid_q && scr_ready_i) scr_valid_q <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (link_ctrl_i[RDEN] && !scr_valid_q) begin
            scr_data_q  <= link_data_i;
            scr_valid_q <= 1'b1;
            rdok_q      <= 1'b1;
            rx_state    <= RX_ACK;
          end
        end
        RX_ACK: begin
          rx_state <= RX_RELEASE;
        end
        RX_RELEASE: begin
          if (!link_ctrl_i[RDEN]) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign link_data_o       = link_data_q;
  assign link_ctrl_o[WREN] = wren_q;
  assign link_ctrl_o[RDOK] = rdok_q;
  assign scr_data_o        = scr_data_q;
  assign scr_valid_o       = scr_valid_q;
  assign kb_timeout_o      = timeout_q;

endmodule

// File: tb/tb_kb_scr_host.sv
// Self-checking bench for kb_scr_host: a transaction-level model of the
// keystroke queue and screen holding register is compared against the DUT on
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_kb_scr_host;

  localparam int DEPTH = 4;
  localparam int ACK   = 255;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    key_data_i;
  logic          key_valid_i;
  logic          key_ready_o;
  logic [7:0]    link_data_o;
  logic [1:0]    link_ctrl_o;
  logic [7:0]    link_data_i;
  logic [1:0]    link_ctrl_i;
  logic [7:0]    scr_data_o;
  logic          scr_valid_o;
  logic          scr_ready_i;
  logic [CW-1:0] kb_count_o;
  logic          kb_timeout_o;

  kb_scr_host #(
    .KB_FIFO_DEPTH(DEPTH),
    .ACK_TIMEOUT  (ACK),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_data_i   (key_data_i),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .link_data_o  (link_data_o),
    .link_ctrl_o  (link_ctrl_o),
    .link_data_i  (link_data_i),
    .link_ctrl_i  (link_ctrl_i),
    .scr_data_o   (scr_data_o),
    .scr_valid_o  (scr_valid_o),
    .scr_ready_i  (scr_ready_i),
    .kb_count_o   (kb_count_o),
    .kb_timeout_o (kb_timeout_o)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;

  // Behavioural model: keystroke queue, transfer timing and screen holding register
  logic [7:0] mq[$];
  logic [7:0] mLinkData;
  bit         mStrobe;
  bit         mWaiting;
  int         mWaited;
  int         mGapLeft;
  bit         mTimeout;
  bit         mScrValid;
  logic [7:0] mScrData;
  bit         mRdok;
  bit         mRelease;
  bit         pushNow;
  bit         drainNow;
  bit         captureNow;
  bit         txFree;

  // Event log gathered from the DUT outputs for the directed checks
  logic [7:0] strobeLog[$];
  int         strobeCount  = 0;
  int         lastStrobe   = -1;
  int         minSpacing   = 1000000;
  int         timeoutCount = 0;
  int         rdokCount    = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      mLinkData = 8'h00;
      mStrobe   = 0;
      mWaiting  = 0;
      mWaited   = 0;
      mGapLeft  = 0;
      mTimeout  = 0;
      mScrValid = 0;
      mScrData  = 8'h00;
      mRdok     = 0;
      mRelease  = 0;
    end else begin
      pushNow  = key_valid_i && (mq.size() < DEPTH);
      txFree   = !mStrobe && !mWaiting && (mGapLeft == 0);
      mTimeout = 0;
      if (txFree && mq.size() > 0) begin
        mLinkData = mq.pop_front();
        mStrobe   = 1;
      end else if (mStrobe) begin
        mStrobe  = 0;
        mWaiting = 1;
        mWaited  = 0;
      end else if (mWaiting) begin
        mWaited++;
        if (link_ctrl_i[0]) begin
          mWaiting = 0;
          mGapLeft = GAP;
        end else if (mWaited == ACK + 1) begin
          mWaiting = 0;
          mGapLeft = GAP;
          mTimeout = 1;
        end
      end else if (mGapLeft > 0) begin
        mGapLeft--;
      end
      if (pushNow) mq.push_back(key_data_i);

      drainNow   = mScrValid && scr_ready_i;
      captureNow = link_ctrl_i[1] && !mScrValid && !mRdok && !mRelease;
      if (mRdok) begin
        mRdok    = 0;
        mRelease = 1;
      end else if (mRelease && !link_ctrl_i[1]) begin
        mRelease = 0;
      end
      if (drainNow) mScrValid = 0;
      if (captureNow) begin
        mScrValid = 1;
        mScrData  = link_data_i;
        mRdok     = 1;
      end
    end
  end

  // Compare every DUT output against the model each cycle, and log link events
  always @(negedge clk) begin
    if (cyc > 0) begin
      checkOutput("key_ready",   32'(key_ready_o),  32'(mq.size() < DEPTH));
      checkOutput("kb_count",    32'(kb_count_o),   32'(mq.size()));
      checkOutput("write_en",    32'(link_ctrl_o[1]), 32'(mStrobe));
      checkOutput("read_ok",     32'(link_ctrl_o[0]), 32'(mRdok));
      checkOutput("link_data",   32'(link_data_o),  32'(mLinkData));
      checkOutput("kb_timeout",  32'(kb_timeout_o), 32'(mTimeout));
      checkOutput("scr_valid",   32'(scr_valid_o),  32'(mScrValid));
      checkOutput("scr_data",    32'(scr_data_o),   32'(mScrData));
    end
    if (!rst_n) lastStrobe = -1;
    if (link_ctrl_o[1] === 1'b1) begin
      strobeLog.push_back(link_data_o);
      strobeCount++;
      if (lastStrobe >= 0 && (cyc - lastStrobe) < minSpacing) minSpacing = cyc - lastStrobe;
      lastStrobe = cyc;
    end
    if (kb_timeout_o === 1'b1)   timeoutCount++;
    if (link_ctrl_o[0] === 1'b1) rdokCount++;
  end

  // Drive one cycle of inputs and return just after the next rising edge
  task automatic applyStimulus(input bit kv, input logic [7:0] kd, input bit wok,
                               input bit ren, input logic [7:0] ldi, input bit srdy);
    key_valid_i = kv;
    key_data_i  = kd;
    link_ctrl_i = {ren, wok};
    link_data_i = ldi;
    scr_ready_i = srdy;
    @(posedge clk);
    #1;
  endtask

  bit sawFull     = 0;
  int fullCount   = 0;

  // Hold a keystroke until it is accepted, bounded
  task automatic pushByte(input logic [7:0] d, input bit wok);
    int g;
    g = 0;
    while (!key_ready_o && g < 2000) begin
      if (!sawFull) begin
        sawFull   = 1;
        fullCount = int'(kb_count_o);
      end
      applyStimulus(1, d, wok, 0, 8'h00, 1);
      g++;
    end
    if (g >= 2000) checkOutput("push_wait_bound", 32'(g), 32'(0));
    applyStimulus(1, d, wok, 0, 8'h00, 1);
  endtask

  task automatic idleCycles(input int n, input bit wok);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, wok, 0, 8'h00, 1);
  endtask

  int base;
  int toBase;
  int rdBase;
  int guard;
  bit renState;

  initial begin
    rst_n       = 1'b0;
    key_valid_i = 1'b0;
    key_data_i  = 8'h00;
    link_data_i = 8'h00;
    link_ctrl_i = 2'b00;
    scr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_key_ready", 32'(key_ready_o), 32'(1));
    checkOutput("rst_link_ctrl", 32'(link_ctrl_o), 32'(0));
    checkOutput("rst_link_data", 32'(link_data_o), 32'(0));
    checkOutput("rst_scr_valid", 32'(scr_valid_o), 32'(0));
    checkOutput("rst_scr_data",  32'(scr_data_o),  32'(0));
    checkOutput("rst_kb_count",  32'(kb_count_o),  32'(0));
    checkOutput("rst_timeout",   32'(kb_timeout_o), 32'(0));
    rst_n = 1'b1;
    idleCycles(2, 0);

    // Single keystroke: strobe two edges after acceptance, exactly one cycle wide
    base = strobeLog.size();
    applyStimulus(1, 8'h41, 0, 0, 8'h00, 1);
    checkOutput("t1_no_early_strobe", 32'(link_ctrl_o[1]), 32'(0));
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1);
    checkOutput("t1_strobe", 32'(link_ctrl_o), 32'(2'b10));
    checkOutput("t1_data",   32'(link_data_o), 32'(8'h41));
    applyStimulus(1, 8'h42, 1, 0, 8'h00, 1);
    checkOutput("t1_strobe_one_cycle", 32'(link_ctrl_o[1]), 32'(0));
    checkOutput("t1_data_held", 32'(link_data_o), 32'(8'h41));
    idleCycles(15, 1);
    checkOutput("t1_strobe_count", 32'(strobeLog.size() - base), 32'(2));
    if (strobeLog.size() - base == 2) checkOutput("t1_second_data", 32'(strobeLog[base+1]), 32'(8'h42));
    checkOutput("t1_spacing_min", 32'(minSpacing >= 2 + GAP), 32'(1));

    // FIFO fill with write_ok stuck low: every byte times out, order preserved
    base   = strobeLog.size();
    toBase = timeoutCount;
    sawFull = 0;
    for (int b = 0; b < 6; b++) pushByte(8'h10 + 8'(b), 0);
    checkOutput("t2_full_seen",  32'(sawFull),   32'(1));
    checkOutput("t2_full_count", 32'(fullCount), 32'(4));
    guard = 0;
    while (((timeoutCount - toBase) < 6) && guard < 3000) begin
      idleCycles(1, 0);
      guard++;
    end
    idleCycles(5, 0);
    checkOutput("t2_timeouts", 32'(timeoutCount - toBase), 32'(6));
    checkOutput("t2_strobes",  32'(strobeLog.size() - base), 32'(6));
    for (int i = 0; i < 6; i++)
      if (base + i < strobeLog.size())
        checkOutput("t2_order", 32'(strobeLog[base+i]), 32'(8'h10 + i));

    // Screen read with ready sink: one read_ok, one capture, no re-capture
    rdBase = rdokCount;
    applyStimulus(0, 8'h00, 1, 1, 8'h5A, 1);
    checkOutput("t3_read_ok",  32'(link_ctrl_o[0]), 32'(1));
    checkOutput("t3_scr_data", 32'(scr_data_o),  32'(8'h5A));
    checkOutput("t3_scr_valid", 32'(scr_valid_o), 32'(1));
    applyStimulus(0, 8'h00, 1, 1, 8'h5A, 1);
    checkOutput("t3_valid_one_cycle", 32'(scr_valid_o), 32'(0));
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 1, 8'h5A, 1);
    checkOutput("t3_single_ack", 32'(rdokCount - rdBase), 32'(1));
    for (int i = 0; i < 2; i++) applyStimulus(0, 8'h00, 1, 0, 8'h00, 1);

    // Backpressure: second byte waits until the first drains
    rdBase = rdokCount;
    applyStimulus(0, 8'h00, 1, 1, 8'h61, 0);
    checkOutput("t4_first_data", 32'(scr_data_o), 32'(8'h61));
    for (int i = 0; i < 2; i++) applyStimulus(0, 8'h00, 1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 1, 8'h62, 0);
    checkOutput("t4_no_ack_blocked", 32'(rdokCount - rdBase), 32'(1));
    checkOutput("t4_held_data", 32'(scr_data_o), 32'(8'h61));
    applyStimulus(0, 8'h00, 1, 1, 8'h62, 1);
    checkOutput("t4_drained", 32'(scr_valid_o), 32'(0));
    applyStimulus(0, 8'h00, 1, 1, 8'h62, 1);
    checkOutput("t4_second_ack",  32'(link_ctrl_o[0]), 32'(1));
    checkOutput("t4_second_data", 32'(scr_data_o), 32'(8'h62));
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 8'h00, 1);

    // Keyboard strobe and screen ack in the same cycle
    applyStimulus(1, 8'h0D, 1, 0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1, 1, 8'h3E, 1);
    checkOutput("t5_both_ctrl", 32'(link_ctrl_o), 32'(2'b11));
    checkOutput("t5_kb_data",   32'(link_data_o), 32'(8'h0D));
    checkOutput("t5_scr_data",  32'(scr_data_o),  32'(8'h3E));
    idleCycles(8, 1);

    // Reset during WAIT_ACK with two bytes queued and a screen byte held
    applyStimulus(0, 8'h00, 0, 1, 8'h77, 0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0);
    for (int b = 0; b < 3; b++) pushByte(8'hA0 + 8'(b), 0);
    idleCycles(5, 0);
    checkOutput("t6_queued", 32'(kb_count_o), 32'(2));
    rst_n = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0);
    checkOutput("t6_count",     32'(kb_count_o),  32'(0));
    checkOutput("t6_ctrl",      32'(link_ctrl_o), 32'(0));
    checkOutput("t6_link_data", 32'(link_data_o), 32'(0));
    checkOutput("t6_scr_valid", 32'(scr_valid_o), 32'(0));
    checkOutput("t6_key_ready", 32'(key_ready_o), 32'(1));
    rst_n = 1'b1;
    base = strobeCount;
    idleCycles(300, 0);
    checkOutput("t6_no_strobe", 32'(strobeCount - base), 32'(0));

    // Randomised traffic with occasional resets, checked against the model
    renState = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 3) == 0) renState = !renState;
      rst_n = ($urandom_range(0, 999) != 0);
      applyStimulus($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) < 4,
                    renState, 8'($urandom), $urandom_range(0, 2) != 0);
    end
    rst_n = 1'b1;
    idleCycles(5, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
